// File: rtl/nclassic_kbd_pkg.sv
// Shared types and helpers for the HP-67 keyboard scan path.
package nclassic_kbd_pkg;

    localparam int KEYCODE_W = 7;

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        PRESSED,
        DEB_REL
    } deb_state_e;

    typedef enum logic {
        SCAN_SETTLE,
        SCAN_SAMPLE
    } scan_state_e;

    function automatic logic [KEYCODE_W-1:0] make_keycode(input logic [3:0] col,
                                                          input logic [2:0] row);
        return {col, row};
    endfunction

endpackage

// File: rtl/kbd_debounce.sv
// Frame-level debounce FSM plus the valid/ack keycode handshake toward the core.
module kbd_debounce
    import nclassic_kbd_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 frame_end_i,
    input  logic                 frame_hit_i,
    input  logic [KEYCODE_W-1:0] frame_code_i,
    input  logic                 key_ack_i,
    output logic                 key_valid_o,
    output logic [KEYCODE_W-1:0] key_code_o,
    output logic                 key_down_o,
    output logic                 overrun_o
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    deb_state_e           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d, cnt_inc;
    logic [KEYCODE_W-1:0] cand_q, cand_d;
    logic                 valid_q, valid_d;
    logic [KEYCODE_W-1:0] code_q, code_d;
    logic                 down_q, down_d;
    logic                 ovr_q, ovr_d;
    logic                 emit, ack_eff;

    assign cnt_inc = cnt_q + CW'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
            valid_q <= 1'b0;
            code_q  <= '0;
            down_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            down_q  <= down_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        emit    = 1'b0;
        if (frame_end_i) begin
            unique case (state_q)
                IDLE: begin
                    if (frame_hit_i) begin
                        cand_d  = frame_code_i;
                        cnt_d   = CW'(1);
                        state_d = DEB_PRESS;
                    end
                end
                DEB_PRESS: begin
                    if (frame_hit_i && (frame_code_i == cand_q)) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
                            emit    = 1'b1;
                            state_d = PRESSED;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
                PRESSED: begin
                    // A different key seen while held is deliberately ignored.
                    if (!frame_hit_i) begin
                        cnt_d   = CW'(1);
                        state_d = DEB_REL;
                    end
                end
                DEB_REL: begin
                    if (frame_hit_i) begin
                        state_d = PRESSED;
                    end else if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        valid_d = valid_q;
        code_d  = code_q;
        ovr_d   = ovr_q;
        ack_eff = key_ack_i && valid_q;
        if (ack_eff) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
        // Emit coinciding with ack reloads the slot instead of counting as an overrun.
        if (emit) begin
            if (!valid_q || ack_eff) begin
                valid_d = 1'b1;
                code_d  = cand_q;
            end else begin
                ovr_d = 1'b1;
            end
        end
        down_d = (state_d == PRESSED) || (state_d == DEB_REL);
    end

    assign key_valid_o = valid_q;
    assign key_code_o  = code_q;
    assign key_down_o  = down_q;
    assign overrun_o   = ovr_q;

endmodule

// File: rtl/kbd_scan_ctrl.sv
// Column scanner with lowest-column/lowest-row priority encoding; feeds frame results to kbd_debounce.
module kbd_scan_ctrl
    import nclassic_kbd_pkg::*;
#(
    parameter int NUM_COLS       = 11,
    parameter int NUM_ROWS       = 8,
    parameter int SETTLE_CYCLES  = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                 clk_in,
    input  logic                 reset_in,
    input  logic                 scan_en_in,
    output logic [NUM_COLS-1:0]  col_drive_o,
    input  logic [NUM_ROWS-1:0]  rows_in,
    output logic                 key_valid_o,
    output logic [KEYCODE_W-1:0] key_code_o,
    input  logic                 key_ack_in,
    output logic                 key_down_o,
    output logic                 overrun_o
);

    localparam int COL_W = 4;
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    scan_state_e          state_q, state_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_COLS-1:0]  drive_q, drive_d;
    logic                 frame_hit_q, frame_hit_d;
    logic [KEYCODE_W-1:0] frame_code_q, frame_code_d;
    logic [NUM_ROWS-1:0]  rows_n;
    logic                 sample_hit;
    logic [2:0]           sample_row;
    logic                 running;
    logic                 frame_end, end_hit;
    logic [KEYCODE_W-1:0] end_code;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q      <= SCAN_SETTLE;
            col_q        <= '0;
            cnt_q        <= '0;
            drive_q      <= '0;
            frame_hit_q  <= 1'b0;
            frame_code_q <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            cnt_q        <= cnt_d;
            drive_q      <= drive_d;
            frame_hit_q  <= frame_hit_d;
            frame_code_q <= frame_code_d;
        end
    end

    always_comb begin
        rows_n     = ~rows_in;
        sample_hit = |rows_n;
        sample_row = '0;
        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            if (rows_n[NUM_ROWS-1-r]) sample_row = 3'(NUM_ROWS - 1 - r);
        end
    end

    // Counting starts only once the column is actually driven, so every column gets a full settle.
    assign running = scan_en_in && (|drive_q);

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        cnt_d        = cnt_q;
        frame_hit_d  = frame_hit_q;
        frame_code_d = frame_code_q;
        frame_end    = 1'b0;
        end_hit      = 1'b0;
        end_code     = '0;
        if (!scan_en_in) begin
            state_d      = SCAN_SETTLE;
            col_d        = '0;
            cnt_d        = '0;
            frame_hit_d  = 1'b0;
            frame_code_d = '0;
        end else if (running) begin
            unique case (state_q)
                SCAN_SETTLE: begin
                    if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                        cnt_d   = '0;
                        state_d = SCAN_SAMPLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                SCAN_SAMPLE: begin
                    end_hit  = frame_hit_q || sample_hit;
                    end_code = frame_hit_q ? frame_code_q : make_keycode(col_q, sample_row);
                    state_d  = SCAN_SETTLE;
                    if (col_q == COL_W'(NUM_COLS - 1)) begin
                        col_d        = '0;
                        frame_end    = 1'b1;
                        frame_hit_d  = 1'b0;
                        frame_code_d = '0;
                    end else begin
                        col_d        = col_q + COL_W'(1);
                        frame_hit_d  = end_hit;
                        frame_code_d = end_code;
                    end
                end
                default: state_d = SCAN_SETTLE;
            endcase
        end
        drive_d = scan_en_in ? (NUM_COLS'(1) << col_d) : '0;
    end

    assign col_drive_o = drive_q;

    kbd_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk_i       (clk_in),
        .rst_i       (reset_in),
        .frame_end_i (frame_end),
        .frame_hit_i (end_hit),
        .frame_code_i(end_code),
        .key_ack_i   (key_ack_in),
        .key_valid_o (key_valid_o),
        .key_code_o  (key_code_o),
        .key_down_o  (key_down_o),
        .overrun_o   (overrun_o)
    );

endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// Directed bench for kbd_scan_ctrl: a key-matrix model pulls rows low under driven columns.
module tb_kbd_scan_ctrl;

    localparam int NC = 11;
    localparam int NR = 8;
    localparam int FR = 187;

    logic          clk = 1'b0;
    logic          reset_in;
    logic          scan_en_in;
    logic [NC-1:0] col_drive_o;
    logic [NR-1:0] rows_in;
    logic          key_valid_o;
    logic [6:0]    key_code_o;
    logic          key_ack_in;
    logic          key_down_o;
    logic          overrun_o;

    logic [NR-1:0] keymat [NC];
    int            cyc;
    int            n_checks = 0;
    int            n_fail   = 0;

    always #5 clk = ~clk;

    kbd_scan_ctrl #(
        .NUM_COLS      (NC),
        .NUM_ROWS      (NR),
        .SETTLE_CYCLES (16),
        .DEBOUNCE_SCANS(4)
    ) dut (
        .clk_in     (clk),
        .reset_in   (reset_in),
        .scan_en_in (scan_en_in),
        .col_drive_o(col_drive_o),
        .rows_in    (rows_in),
        .key_valid_o(key_valid_o),
        .key_code_o (key_code_o),
        .key_ack_in (key_ack_in),
        .key_down_o (key_down_o),
        .overrun_o  (overrun_o)
    );

    always_comb begin
        rows_in = '1;
        for (int c = 0; c < NC; c++) begin
            if (col_drive_o[c]) rows_in = rows_in & ~keymat[c];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic goto(input int target);
        while (cyc < target) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic clear_keys();
        for (int c = 0; c < NC; c++) keymat[c] = '0;
    endtask

    task automatic press(input int c, input int r);
        keymat[c][r] = 1'b1;
    endtask

    task automatic pulse_ack();
        key_ack_in = 1'b1;
        @(negedge clk);
        cyc++;
        key_ack_in = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_in = 1'b0;
        cyc = 0;
    endtask

    initial begin
        reset_in   = 1'b1;
        scan_en_in = 1'b1;
        key_ack_in = 1'b0;
        cyc        = 0;
        clear_keys();
        repeat (3) @(negedge clk);
        check("rst_drive", 32'(col_drive_o), 32'h0);
        check("rst_valid", 32'(key_valid_o), 32'h0);
        check("rst_code", 32'(key_code_o), 32'h0);
        check("rst_down", 32'(key_down_o), 32'h0);
        check("rst_ovr", 32'(overrun_o), 32'h0);
        release_reset();

        // Column walk, first and last cycle of every column, then wrap.
        for (int k = 0; k < NC; k++) begin
            goto(1 + 17 * k);
            check("walk_first", 32'(col_drive_o), 32'(1) << k);
            goto(17 + 17 * k);
            check("walk_last", 32'(col_drive_o), 32'(1) << k);
        end
        goto(FR + 1);
        check("walk_wrap", 32'(col_drive_o), 32'h001);
        check("idle_valid", 32'(key_valid_o), 32'h0);

        // col3/row2 held frames 3..8
        goto(FR * 2 + 1);
        press(3, 2);
        goto(FR * 6);
        check("press_early_valid", 32'(key_valid_o), 32'h0);
        check("press_early_down", 32'(key_down_o), 32'h0);
        goto(FR * 6 + 1);
        check("press_valid", 32'(key_valid_o), 32'h1);
        check("press_code", 32'(key_code_o), 32'h1A);
        check("press_down", 32'(key_down_o), 32'h1);
        pulse_ack();
        check("ack_valid", 32'(key_valid_o), 32'h0);
        goto(FR * 8 + 1);
        check("hold_no_reemit", 32'(key_valid_o), 32'h0);
        check("hold_down", 32'(key_down_o), 32'h1);

        // Release frames 9..12
        clear_keys();
        goto(FR * 12);
        check("rel_still_down", 32'(key_down_o), 32'h1);
        goto(FR * 12 + 1);
        check("rel_down", 32'(key_down_o), 32'h0);

        // Bounce: 2 on, 1 off, 2 on, then off
        press(3, 2);
        goto(FR * 14 + 1);
        clear_keys();
        goto(FR * 15 + 1);
        press(3, 2);
        goto(FR * 17 + 1);
        clear_keys();
        check("bounce_valid", 32'(key_valid_o), 32'h0);
        check("bounce_down", 32'(key_down_o), 32'h0);
        goto(FR * 21 + 1);
        check("bounce_valid_late", 32'(key_valid_o), 32'h0);
        check("bounce_down_late", 32'(key_down_o), 32'h0);

        // Priority: col1/row0 and col5/row6 together, frames 22..25
        press(1, 0);
        press(5, 6);
        goto(FR * 25 + 1);
        check("prio_valid", 32'(key_valid_o), 32'h1);
        check("prio_code", 32'(key_code_o), 32'h08);
        clear_keys();
        pulse_ack();

        // Overrun: 0x1A unacked, release, then col0/row4
        goto(FR * 29 + 1);
        press(3, 2);
        goto(FR * 33 + 1);
        check("ovr_first_valid", 32'(key_valid_o), 32'h1);
        check("ovr_first_code", 32'(key_code_o), 32'h1A);
        clear_keys();
        goto(FR * 37 + 1);
        press(0, 4);
        goto(FR * 41);
        check("ovr_before", 32'(overrun_o), 32'h0);
        goto(FR * 41 + 1);
        check("ovr_set", 32'(overrun_o), 32'h1);
        check("ovr_code_kept", 32'(key_code_o), 32'h1A);
        check("ovr_valid", 32'(key_valid_o), 32'h1);
        check("ovr_down", 32'(key_down_o), 32'h1);

        // Emit col2/row1 in the same cycle as ack
        clear_keys();
        goto(FR * 45 + 1);
        press(2, 1);
        goto(FR * 49);
        key_ack_in = 1'b1;
        goto(FR * 49 + 1);
        key_ack_in = 1'b0;
        check("same_cyc_valid", 32'(key_valid_o), 32'h1);
        check("same_cyc_code", 32'(key_code_o), 32'h11);
        check("same_cyc_ovr", 32'(overrun_o), 32'h0);
        clear_keys();

        // Reset during debounce of col3/row2
        goto(FR * 53 + 1);
        press(3, 2);
        goto(FR * 56 + 60);
        reset_in = 1'b1;
        #1;
        check("mid_rst_drive", 32'(col_drive_o), 32'h0);
        check("mid_rst_valid", 32'(key_valid_o), 32'h0);
        check("mid_rst_code", 32'(key_code_o), 32'h0);
        check("mid_rst_down", 32'(key_down_o), 32'h0);
        check("mid_rst_ovr", 32'(overrun_o), 32'h0);
        repeat (3) @(negedge clk);
        release_reset();
        goto(1);
        check("post_rst_drive", 32'(col_drive_o), 32'h001);
        goto(FR * 4);
        check("post_rst_early", 32'(key_valid_o), 32'h0);
        goto(FR * 4 + 1);
        check("post_rst_valid", 32'(key_valid_o), 32'h1);
        check("post_rst_code", 32'(key_code_o), 32'h1A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
